// File: rtl/grf_wb_arbiter.sv
// GRF write-port arbiter: shares the single write port between W-stage writeback and the
// long-latency return path, defers losing returns in a FIFO, and scoreboards pending writes.
module grf_wb_arbiter #(
  parameter int unsigned DEPTH    = 2,
  parameter int unsigned MAX_WAIT = 4
) (
  input  logic        clk,
  input  logic        reset,
  // W-stage write request
  input  logic        w_we,
  input  logic [4:0]  w_a3,
  input  logic [31:0] w_wd,
  input  logic [31:0] w_pc,
  input  logic [31:0] w_instr,
  output logic        w_hold,
  // long-latency return
  input  logic        l_valid,
  input  logic [4:0]  l_a3,
  input  logic [31:0] l_wd,
  input  logic [31:0] l_pc,
  input  logic [31:0] l_instr,
  output logic        l_ready,
  // long-op issue and D-stage hazard query
  input  logic        iss_valid,
  input  logic [4:0]  iss_a3,
  input  logic [4:0]  d_a1,
  input  logic [4:0]  d_a2,
  input  logic [4:0]  d_a3,
  output logic        d_stall,
  // GRF write port
  output logic        grf_we,
  output logic [4:0]  grf_a3,
  output logic [31:0] grf_wd,
  output logic [31:0] grf_pc,
  output logic [31:0] grf_instr
);

  localparam int unsigned CntW  = $clog2(DEPTH + 1);
  localparam int unsigned PtrW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned WaitW = $clog2(MAX_WAIT + 1);

  typedef struct packed {
    logic [4:0]  a3;
    logic [31:0] wd;
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  typedef enum logic [1:0] {SelNone, SelW, SelFifo, SelPass} sel_e;

  entry_t            mem_q [DEPTH];
  entry_t            mem_d [DEPTH];
  logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [WaitW-1:0]  wait_q, wait_d;
  logic [31:0]       busy_q, busy_d;

  logic   fifo_empty, fifo_full;
  logic   w_req, l_acc, l_req, forced;
  logic   push, pop;
  sel_e   sel;
  entry_t head, l_entry, w_entry, sel_entry;
  logic [31:0] clr_vec, busy_eff;

  assign fifo_empty = (cnt_q == '0);
  assign fifo_full  = (cnt_q == CntW'(DEPTH));
  assign head       = mem_q[rd_ptr_q];
  assign l_entry    = '{a3: l_a3, wd: l_wd, pc: l_pc, instr: l_instr};
  assign w_entry    = '{a3: w_a3, wd: w_wd, pc: w_pc, instr: w_instr};

  // Every request is qualified with reset so nothing is selected while reset is held.
  assign l_ready = reset & ~fifo_full;
  assign l_acc   = l_valid & l_ready;
  assign l_req   = l_acc & (l_a3 != 5'd0);
  assign w_req   = reset & w_we & (w_a3 != 5'd0);
  assign forced  = reset & ~fifo_empty & (wait_q == WaitW'(MAX_WAIT));

  always_comb begin
    sel = SelNone;
    if (forced) begin
      sel = SelFifo;
    end else if (w_req) begin
      sel = SelW;
    end else if (reset && !fifo_empty) begin
      sel = SelFifo;
    end else if (l_req) begin
      sel = SelPass;
    end
  end

  assign w_hold = forced & w_req;
  assign pop    = (sel == SelFifo);
  assign push   = l_req & (sel != SelPass);

  always_comb begin
    sel_entry = '0;
    unique case (sel)
      SelW:    sel_entry = w_entry;
      SelFifo: sel_entry = head;
      SelPass: sel_entry = l_entry;
      default: sel_entry = '0;
    endcase
  end

  assign grf_we    = (sel != SelNone);
  assign grf_a3    = sel_entry.a3;
  assign grf_wd    = sel_entry.wd;
  assign grf_pc    = sel_entry.pc;
  assign grf_instr = sel_entry.instr;

  // FIFO next state
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = mem_q[i];
    end
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    if (push) begin
      mem_d[wr_ptr_q] = l_entry;
      wr_ptr_d = (wr_ptr_q == PtrW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == PtrW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
    end
    if (push && !pop) begin
      cnt_d = cnt_q + 1'b1;
    end else if (pop && !push) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    wait_d = wait_q;
    if (pop) begin
      wait_d = '0;
    end else if (!fifo_empty && wait_q != WaitW'(MAX_WAIT)) begin
      wait_d = wait_q + 1'b1;
    end
  end

  // Scoreboard: a long write clears its bit, a same-cycle issue to that register re-sets it.
  always_comb begin
    clr_vec = '0;
    if (sel == SelFifo || sel == SelPass) begin
      clr_vec[sel_entry.a3] = 1'b1;
    end
    busy_d = busy_q & ~clr_vec;
    if (iss_valid && iss_a3 != 5'd0) begin
      busy_d[iss_a3] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  assign busy_eff = busy_q & ~clr_vec;
  assign d_stall  = reset & (busy_eff[d_a1] | busy_eff[d_a2] | busy_eff[d_a3]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      wait_q   <= '0;
      busy_q   <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= mem_d[i];
      end
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      wait_q   <= wait_d;
      busy_q   <= busy_d;
    end
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Directed bench for grf_wb_arbiter with DEPTH=2, MAX_WAIT=4.
module tb_grf_wb_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        w_we;
  logic [4:0]  w_a3;
  logic [31:0] w_wd, w_pc, w_instr;
  logic        w_hold;
  logic        l_valid;
  logic [4:0]  l_a3;
  logic [31:0] l_wd, l_pc, l_instr;
  logic        l_ready;
  logic        iss_valid;
  logic [4:0]  iss_a3, d_a1, d_a2, d_a3;
  logic        d_stall;
  logic        grf_we;
  logic [4:0]  grf_a3;
  logic [31:0] grf_wd, grf_pc, grf_instr;

  int n_tests = 0;
  int n_fail  = 0;

  grf_wb_arbiter #(.DEPTH(2), .MAX_WAIT(4)) dut (
    .clk(clk), .reset(reset),
    .w_we(w_we), .w_a3(w_a3), .w_wd(w_wd), .w_pc(w_pc), .w_instr(w_instr), .w_hold(w_hold),
    .l_valid(l_valid), .l_a3(l_a3), .l_wd(l_wd), .l_pc(l_pc), .l_instr(l_instr),
    .l_ready(l_ready),
    .iss_valid(iss_valid), .iss_a3(iss_a3), .d_a1(d_a1), .d_a2(d_a2), .d_a3(d_a3),
    .d_stall(d_stall),
    .grf_we(grf_we), .grf_a3(grf_a3), .grf_wd(grf_wd), .grf_pc(grf_pc), .grf_instr(grf_instr)
  );

  always #5 clk = ~clk;

  task automatic idle();
    w_we = 0; w_a3 = 0; w_wd = 0; w_pc = 0; w_instr = 0;
    l_valid = 0; l_a3 = 0; l_wd = 0; l_pc = 0; l_instr = 0;
    iss_valid = 0; iss_a3 = 0; d_a1 = 0; d_a2 = 0; d_a3 = 0;
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 3 units later.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    idle();
    reset = 0;
    w_we = 1; w_a3 = 5; w_wd = 32'h1234;
    l_valid = 1; l_a3 = 3; l_wd = 32'h55;
    step(); #3;
    n_tests++;
    if (grf_we !== 1'b0) begin n_fail++; $display("FAIL reset_grf_we got %b exp 0", grf_we); end
    n_tests++;
    if (l_ready !== 1'b0) begin n_fail++; $display("FAIL reset_l_ready got %b exp 0", l_ready); end
    n_tests++;
    if (grf_a3 !== 5'd0 || w_hold !== 1'b0)
      begin n_fail++; $display("FAIL reset_outs got a3=%0d hold=%b exp 0/0", grf_a3, w_hold); end
    reset = 1; l_valid = 0;
    #1;
    n_tests++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd5 || grf_wd !== 32'h1234)
      begin n_fail++; $display("FAIL w_write got we=%b a3=%0d wd=%h exp 1/5/1234",
                               grf_we, grf_a3, grf_wd); end
    step();
  endtask

  task automatic test_pass_through();
    idle();
    l_valid = 1; l_a3 = 8; l_wd = 32'hABCD; l_pc = 32'h3000;
    #3;
    n_tests++;
    if (l_ready !== 1'b1) begin n_fail++; $display("FAIL pass_ready got %b exp 1", l_ready); end
    n_tests++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd8 || grf_wd !== 32'hABCD || grf_pc !== 32'h3000)
      begin n_fail++; $display("FAIL pass_write got we=%b a3=%0d wd=%h pc=%h exp 1/8/abcd/3000",
                               grf_we, grf_a3, grf_wd, grf_pc); end
    step();
    l_valid = 0;
    #3;
    n_tests++;
    if (grf_we !== 1'b0) begin n_fail++; $display("FAIL pass_fifo_empty got we=%b exp 0", grf_we); end
    step();
  endtask

  task automatic test_forced();
    idle();
    w_we = 1; w_a3 = 1; w_wd = 32'h100;
    l_valid = 1; l_a3 = 9; l_wd = 32'h99;
    #3;
    n_tests++;
    if (grf_a3 !== 5'd1 || w_hold !== 1'b0)
      begin n_fail++; $display("FAIL forced_c0 got a3=%0d hold=%b exp 1/0", grf_a3, w_hold); end
    step();
    l_valid = 0;
    for (int c = 1; c <= 4; c++) begin
      w_a3 = 5'(c + 1); w_wd = 32'h100 + 32'(c);
      #3;
      n_tests++;
      if (grf_a3 !== 5'(c + 1) || w_hold !== 1'b0)
        begin n_fail++; $display("FAIL forced_w_wins c%0d got a3=%0d hold=%b exp %0d/0",
                                 c, grf_a3, w_hold, c + 1); end
      step();
    end
    w_a3 = 6; w_wd = 32'h600;
    #3;
    n_tests++;
    if (grf_a3 !== 5'd9 || grf_wd !== 32'h99 || w_hold !== 1'b1)
      begin n_fail++; $display("FAIL forced_c5 got a3=%0d wd=%h hold=%b exp 9/99/1",
                               grf_a3, grf_wd, w_hold); end
    step();
    #3;
    n_tests++;
    if (grf_a3 !== 5'd6 || grf_wd !== 32'h600 || w_hold !== 1'b0)
      begin n_fail++; $display("FAIL forced_c6 got a3=%0d wd=%h hold=%b exp 6/600/0",
                               grf_a3, grf_wd, w_hold); end
    step();
  endtask

  task automatic test_back_to_back();
    idle();
    w_we = 1; w_a3 = 1; w_wd = 32'h1;
    l_valid = 1;
    for (int c = 0; c < 3; c++) begin
      l_a3 = 5'(10 + c); l_wd = 32'hA0 + 32'(c);
      #3;
      n_tests++;
      if (l_ready !== (c < 2))
        begin n_fail++; $display("FAIL b2b_ready c%0d got %b exp %b", c, l_ready, c < 2); end
      step();
    end
    // Register c stays presented; waits 3 and 4 elapse before the forced pop of register a.
    for (int c = 0; c < 2; c++) begin
      #3;
      n_tests++;
      if (l_ready !== 1'b0 || grf_a3 !== 5'd1)
        begin n_fail++; $display("FAIL b2b_full c%0d got ready=%b a3=%0d exp 0/1",
                                 c, l_ready, grf_a3); end
      step();
    end
    #3;
    n_tests++;
    if (grf_a3 !== 5'd10 || w_hold !== 1'b1 || l_ready !== 1'b0)
      begin n_fail++; $display("FAIL b2b_pop_a got a3=%0d hold=%b ready=%b exp 10/1/0",
                               grf_a3, w_hold, l_ready); end
    step();
    #3;
    n_tests++;
    if (l_ready !== 1'b1 || grf_a3 !== 5'd1)
      begin n_fail++; $display("FAIL b2b_reready got ready=%b a3=%0d exp 1/1", l_ready, grf_a3); end
    step();
    l_valid = 0;
    for (int c = 0; c < 3; c++) step();
    #3;
    n_tests++;
    if (grf_a3 !== 5'd11 || grf_wd !== 32'hA1 || w_hold !== 1'b1)
      begin n_fail++; $display("FAIL b2b_pop_b got a3=%0d wd=%h hold=%b exp 11/a1/1",
                               grf_a3, grf_wd, w_hold); end
    step();
    w_we = 0;
    #3;
    n_tests++;
    if (grf_we !== 1'b1 || grf_a3 !== 5'd12 || grf_wd !== 32'hA2)
      begin n_fail++; $display("FAIL b2b_pop_c got we=%b a3=%0d wd=%h exp 1/12/a2",
                               grf_we, grf_a3, grf_wd); end
    step();
    #3;
    n_tests++;
    if (grf_we !== 1'b0) begin n_fail++; $display("FAIL b2b_drained got we=%b exp 0", grf_we); end
    step();
  endtask

  task automatic test_scoreboard();
    idle();
    iss_valid = 1; iss_a3 = 7; d_a1 = 7;
    #3;
    n_tests++;
    if (d_stall !== 1'b0) begin n_fail++; $display("FAIL sb_not_yet got %b exp 0", d_stall); end
    step();
    iss_valid = 0;
    #3;
    n_tests++;
    if (d_stall !== 1'b1) begin n_fail++; $display("FAIL sb_raw got %b exp 1", d_stall); end
    d_a1 = 0; d_a3 = 7;
    #1;
    n_tests++;
    if (d_stall !== 1'b1) begin n_fail++; $display("FAIL sb_waw got %b exp 1", d_stall); end
    step();
    d_a3 = 0; d_a1 = 7;
    l_valid = 1; l_a3 = 7; l_wd = 32'h77; iss_valid = 1; iss_a3 = 7;
    #3;
    n_tests++;
    if (d_stall !== 1'b0 || grf_a3 !== 5'd7)
      begin n_fail++; $display("FAIL sb_clear got stall=%b a3=%0d exp 0/7", d_stall, grf_a3); end
    step();
    l_valid = 0; iss_valid = 0;
    #3;
    n_tests++;
    if (d_stall !== 1'b1) begin n_fail++; $display("FAIL sb_set_wins got %b exp 1", d_stall); end
    step();
    l_valid = 1;
    step();
    l_valid = 0; d_a2 = 7; d_a1 = 0;
    #3;
    n_tests++;
    if (d_stall !== 1'b0) begin n_fail++; $display("FAIL sb_cleared got %b exp 0", d_stall); end
    step();
  endtask

  task automatic test_zero_reg();
    idle();
    iss_valid = 1; iss_a3 = 0; l_valid = 1; l_a3 = 0; l_wd = 32'hDEAD;
    w_we = 1; w_a3 = 0;
    #3;
    n_tests++;
    if (l_ready !== 1'b1 || grf_we !== 1'b0)
      begin n_fail++; $display("FAIL zero_drop got ready=%b we=%b exp 1/0", l_ready, grf_we); end
    step();
    idle();
    #3;
    n_tests++;
    if (grf_we !== 1'b0 || d_stall !== 1'b0)
      begin n_fail++; $display("FAIL zero_after got we=%b stall=%b exp 0/0", grf_we, d_stall); end
    step();
  endtask

  task automatic test_reset_mid();
    idle();
    w_we = 1; w_a3 = 2; l_valid = 1; l_a3 = 13; iss_valid = 1; iss_a3 = 14;
    step();
    l_valid = 0; iss_valid = 0;
    #2;
    reset = 0;
    #2;
    reset = 1;
    idle();
    d_a1 = 14;
    #1;
    n_tests++;
    if (grf_we !== 1'b0 || d_stall !== 1'b0 || l_ready !== 1'b1)
      begin n_fail++; $display("FAIL reset_mid got we=%b stall=%b ready=%b exp 0/0/1",
                               grf_we, d_stall, l_ready); end
    step();
  endtask

  initial begin
    idle();
    reset = 0;
    test_reset();
    test_pass_through();
    test_forced();
    test_back_to_back();
    test_scoreboard();
    test_zero_reg();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/grf_wb_arbiter.md
# grf_wb_arbiter

Write-port arbiter and scoreboard for the 32×32 general register file. It shares the single GRF write port between the W-stage writeback and a long-latency return path (multiply/divide or extension unit), and buffers returns that lose arbitration. It also tracks which registers have a long-latency write outstanding, so D-stage hazard logic can stall dependent instructions. It sits between W stage / long-latency unit and the GRF write inputs (WE, A3, WD, WPC, instr).

## Interface
- DEPTH, 2, deferred-return FIFO entries (≥1)
- MAX_WAIT, 4, consecutive cycles a FIFO head may lose to W before W is held (≥1)

- clk  input  1  clock, all state on rising edge
- reset  input  1  asynchronous, active-low (0 = reset)
- w_we, w_a3[4:0], w_wd[31:0], w_pc[31:0], w_instr[31:0]  input  W-stage write request
- w_hold  output  1  W write not performed this cycle; W stage must freeze and re-present it
- l_valid, l_a3[4:0], l_wd[31:0], l_pc[31:0], l_instr[31:0]  input  long-latency return
- l_ready  output  1  return accepted this cycle when l_valid&l_ready
- iss_valid, iss_a3[4:0]  input  long op issued; marks iss_a3 busy
- d_a1, d_a2, d_a3[4:0]  input  D-stage source/destination registers
- d_stall  output  1  D-stage instruction depends on an outstanding long write
- grf_we, grf_a3[4:0], grf_wd[31:0], grf_pc[31:0], grf_instr[31:0]  output  to GRF write port

## Operation
- W request valid = w_we & (w_a3≠0). Long request valid = l_valid & l_ready & (l_a3≠0); l_a3=0 returns are accepted and dropped.
- Per-cycle write-port priority:
  1. FIFO head when wait count = MAX_WAIT (forced); w_hold=1 if W request valid.
  2. Otherwise a valid W request.
  3. Otherwise the FIFO head.
  4. Otherwise an accepted return, passed straight through (only when FIFO empty).
- An accepted return not written this cycle is pushed to FIFO tail. The FIFO is in order, and the head is popped when written.
- l_ready = FIFO not full. A full FIFO that pops this cycle still reports l_ready=0 (no same-cycle push-on-pop).
- Wait counter: increments each cycle the FIFO is non-empty and the head is not written. Clears on pop and saturates at MAX_WAIT.
- grf_* = selected requester's a3/wd/pc/instr. grf_we=0 and other grf_* = 0 when nothing is selected.
- Scoreboard busy[31:1]:
  - Set on iss_valid & iss_a3≠0.
  - Cleared when a long write (FIFO or pass-through) to that register drives the port.
  - Set and clear of the same register in one cycle: set wins.
  - Register 0 is never busy.
- d_stall = any of d_a1, d_a2, d_a3 with busy=1 and not being cleared by this cycle's long write. This relies on GRF internal forwarding for the clearing case. d_a3 covers WAW.
- A W write to a busy register is a protocol error. It is prevented upstream by d_stall and is not checked.

## Timing
- Reset (reset=0, asynchronous):
  - FIFO empty, busy all 0, wait counter 0.
  - While asserted: grf_we=0, grf_* = 0, w_hold=0, l_ready=0, d_stall=0.
- Outputs are combinational from inputs and state in the same cycle. The GRF commits on the next rising edge.
- Return latency to the GRF:
  - 0 cycles if the FIFO is empty and W is idle.
  - Otherwise the return waits behind the FIFO.
  - Worst case is bounded by (DEPTH)·(MAX_WAIT+1) cycles.
- Scoreboard set is visible on d_stall the cycle after iss_valid. A clear releases d_stall in the same cycle.
- Reset mid-operation discards FIFO contents and busy bits; no writes are emitted.

## Test plan
- Reset held, l_valid=1, w_we=1 → grf_we=0, l_ready=0. Release, W writes $5=0x1234 → grf_we=1, grf_a3=5, grf_wd=0x1234, same cycle.
- W idle, FIFO empty, return $8=0xABCD → pass-through same cycle, l_ready=1, FIFO stays empty.
- W writes every cycle, return $9 arrives → pushed. MAX_WAIT=4: cycles 1–4 W wins. Cycle 5: grf_a3=9, w_hold=1. Cycle 6: W's held write commits.
- W busy every cycle, three returns back to back, DEPTH=2 → the first two are accepted, then l_ready=0. They drain in order $a,$b, and l_ready reasserts after the first pop.
- iss_valid, iss_a3=7 → next cycle d_a1=7 gives d_stall=1. In the cycle the return for $7 is written, d_stall=0 and busy[7] clears. iss_a3=7 in that same cycle leaves busy[7]=1.
- iss_a3=0 and a return with l_a3=0 → no busy bit set, no GRF write, l_ready=1.
